counter_ctrl: RTL and testbench
===============================

COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 SHALL have parameter DIV_MAX, default 99_999_999, prescaler terminal value (enable rate = clk/(DIV_MAX+1)); legal range 1..2^27-1.
REQ-002 SHALL have parameter TERM, default 6'd63, counter terminal value for stop-at-terminal mode.
REQ-003 SHALL have port clk  input  1  clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  single-cycle pulse from the debouncer; run request.
REQ-006 SHALL have port stop  input  1  single-cycle pulse; pause or acknowledge request.
REQ-007 SHALL have port step  input  1  single-cycle pulse; single-increment request.
REQ-008 SHALL have port mode_wrap  input  1  1 = free-run through wrap; 0 = halt at TERM.
REQ-009 SHALL have port cnt_in  input  6  current value of the controlled 6-bit counter.
REQ-010 SHALL have port cnt_en  output  1  registered enable to the counter; single-cycle pulses only.
REQ-011 SHALL have port state  output  2  current FSM state encoding.
REQ-012 SHALL have port done  output  1  high while in DONE.

Function
REQ-013 SHALL implement states IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, DONE=2'b11.
REQ-014 SHALL resolve same-cycle requests with priority stop > start > step.
REQ-015 SHALL move IDLE/PAUSE -> RUN on start, clearing the 27-bit prescaler p to 0 on entry.
REQ-016 SHALL, in RUN, increment p each cycle and wrap it from DIV_MAX to 0.
REQ-017 SHALL assert cnt_en for exactly one cycle after each edge at which p==DIV_MAX in RUN; first pulse appears DIV_MAX+1 cycles after RUN entry.
REQ-018 SHALL, at an edge with p==DIV_MAX, mode_wrap=0 and cnt_in==TERM, enter DONE and leave cnt_en low.
REQ-019 SHALL, with mode_wrap=1, never enter DONE; counter wraps 63 -> 0 naturally.
REQ-020 SHALL move RUN -> PAUSE on stop; p holds its value; a pending cnt_en pulse is suppressed.
REQ-021 SHALL move DONE -> IDLE on stop; start in DONE is ignored.
REQ-022 SHALL, on step in IDLE, PAUSE or DONE, emit one cnt_en pulse on the following cycle and enter PAUSE; step in RUN is ignored.
REQ-023 SHALL drive done = (state==DONE), registered.
REQ-024 SHALL sample mode_wrap only at terminal-check edges; changes elsewhere have no effect.

Reset
REQ-025 SHALL, on rst low, immediately force state=IDLE, p=0, cnt_en=0, done=0, regardless of clock.
REQ-026 SHALL, on reset mid-RUN, discard any pending enable; no cnt_en pulse after reset release until a new start/step.
REQ-027 SHALL ignore start/stop/step in the first clock edge after rst deassertion.

Configuration
REQ-028 SHALL support macro COUNTER_CTRL_STEP_EN: defined -> step behaves per REQ-022; undefined -> step port remains but is ignored and no step logic is synthesised.

Structure
REQ-029 SHALL take state encodings, CNT_W=6 and PRE_W=27 from shared package counter_pkg.
REQ-030 SHALL place the prescaler in sub-module tick_gen (inputs clr, run; output tick when p==DIV_MAX).
REQ-031 SHALL keep all outputs registered; no combinational input-to-output path.

Verification (DIV_MAX=3, TERM=5, step macro defined)
REQ-032 SHALL cover: reset, start, mode_wrap=1 -> cnt_en pulses every 4 cycles, first 4 cycles after RUN entry; cnt 1,2,...,63,0,1.
REQ-033 SHALL cover: mode_wrap=0, run from cnt=1 -> four pulses (cnt reaches 5), then state=DONE, done=1, no further cnt_en.
REQ-034 SHALL cover: stop 2 cycles after a pulse -> PAUSE, p held; start -> next pulse after remaining 2 cycles, not 4.
REQ-035 SHALL cover: start+stop same cycle in IDLE -> stays IDLE; step in DONE -> one pulse, cnt 5->6, state PAUSE.
REQ-036 SHALL cover: rst asserted asynchronously mid-RUN with p==3 -> cnt_en=0 and state=IDLE before next edge; no pulse after release.
REQ-037 SHALL cover: build without COUNTER_CTRL_STEP_EN, pulse step in IDLE -> no cnt_en, state stays IDLE.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared widths and FSM state encoding for the counter controller slice.
package counter_pkg;

   localparam int unsigned CNT_W = 6;
   localparam int unsigned PRE_W = 27;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      DONE  = 2'b11
   } ctrl_state_e;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIV_MAX while run is high; tick flags the terminal count.
module tick_gen
   import counter_pkg::*;
#(
   parameter int unsigned DIV_MAX = 99_999_999
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic run,
   output logic tick
);

   logic [PRE_W-1:0] p_q, p_d;

   assign tick = (p_q == PRE_W'(DIV_MAX));

   always_comb begin
      p_d = p_q;
      if (clr) begin
         p_d = '0;
      end else if (run) begin
         p_d = tick ? '0 : p_q + PRE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_q <= '0;
      end else begin
         p_q <= p_d;
      end
   end

endmodule

// File: rtl/counter_ctrl.sv
// Run/pause/step controller issuing prescaled single-cycle enables to a 6-bit counter.
// Step requests are honoured only when COUNTER_CTRL_STEP_EN is defined.
module counter_ctrl
   import counter_pkg::*;
#(
   parameter int unsigned           DIV_MAX = 99_999_999,
   parameter logic [CNT_W-1:0]      TERM    = 6'd63
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             step,
   input  logic             mode_wrap,
   input  logic [CNT_W-1:0] cnt_in,
   output logic             cnt_en,
   output logic [1:0]       state,
   output logic             done
);

   ctrl_state_e state_q, state_d;
   logic        cnt_en_q, cnt_en_d;
   logic        done_q;
   logic        arm_q;
   logic        req_start_c, req_stop_c, req_step_c;
   logic        run_c, clr_c, tick_c, at_term_c;

   // Requests are masked on the first edge after reset release.
   assign req_start_c = arm_q & start;
   assign req_stop_c  = arm_q & stop;

`ifdef COUNTER_CTRL_STEP_EN
   assign req_step_c = arm_q & step;
`else
   logic unused_step;
   assign unused_step = step;
   assign req_step_c  = 1'b0;
`endif

   // Prescaler resumes from its held value out of PAUSE; IDLE and DONE park it at zero.
   assign run_c     = (state_q == RUN) && !req_stop_c;
   assign clr_c     = (state_q == IDLE) || (state_q == DONE);
   assign at_term_c = !mode_wrap && (cnt_in == TERM);

   tick_gen #(
      .DIV_MAX (DIV_MAX)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr_c),
      .run  (run_c),
      .tick (tick_c)
   );

   always_comb begin
      state_d  = state_q;
      cnt_en_d = 1'b0;
      unique case (state_q)
         IDLE, PAUSE: begin
            if (req_stop_c) begin
               state_d = state_q;
            end else if (req_start_c) begin
               state_d = RUN;
            end else if (req_step_c) begin
               state_d  = PAUSE;
               cnt_en_d = 1'b1;
            end
         end
         RUN: begin
            if (req_stop_c) begin
               state_d = PAUSE;
            end else if (tick_c) begin
               if (at_term_c) begin
                  state_d = DONE;
               end else begin
                  cnt_en_d = 1'b1;
               end
            end
         end
         DONE: begin
            if (req_stop_c) begin
               state_d = IDLE;
            end else if (req_step_c) begin
               state_d  = PAUSE;
               cnt_en_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_en_q <= 1'b0;
         done_q   <= 1'b0;
         arm_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_en_q <= cnt_en_d;
         done_q   <= (state_d == DONE);
         arm_q    <= 1'b1;
      end
   end

   assign cnt_en = cnt_en_q;
   assign state  = state_q;
   assign done   = done_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with DIV_MAX=3, TERM=5 and an external 6-bit counter.
module tb_counter_ctrl;

   localparam int unsigned DIV_MAX = 3;
   localparam logic [5:0]  TERM    = 6'd5;

   logic       clk;
   logic       rst;
   logic       start, stop, step, mode_wrap;
   logic [5:0] cnt;
   logic       cnt_en;
   logic [1:0] state;
   logic       done;
   logic       load;
   logic [5:0] load_val;
   int         total = 0;
   int         bad   = 0;
   int         pulses;

   counter_ctrl #(
      .DIV_MAX (DIV_MAX),
      .TERM    (TERM)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .step      (step),
      .mode_wrap (mode_wrap),
      .cnt_in    (cnt),
      .cnt_en    (cnt_en),
      .state     (state),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The controlled counter
   always @(posedge clk) begin
      if (load) cnt <= load_val;
      else if (cnt_en) cnt <= cnt + 6'd1;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #2;
      rst = 1'b1;
      cyc();
   endtask

   task automatic load_cnt(input logic [5:0] v);
      load_val = v;
      load     = 1'b1;
      cyc();
      load     = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   // One prescaler period in RUN: three quiet cycles then one enable.
   task automatic period(input string tag);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk({tag, "_quiet"}, 8'(cnt_en), 8'd0);
      end
      cyc();
      chk({tag, "_pulse"}, 8'(cnt_en), 8'd1);
   endtask

   task automatic count_pulses(input int n);
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         cyc();
         if (cnt_en) pulses++;
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
      mode_wrap = 1'b1; load = 1'b0; load_val = 6'd0;

      // reset state, then a request on the first edge after release is ignored
      #12;
      chk("rst_state", 8'(state), 8'd0);
      chk("rst_en", 8'(cnt_en), 8'd0);
      chk("rst_done", 8'(done), 8'd0);
      start = 1'b1;
      rst   = 1'b1;
      cyc();
      start = 1'b0;
      chk("arm_ignore", 8'(state), 8'd0);

      // free-run with wrap: 64 periods, counter 1 -> ... -> 63 -> 0 -> 1
      load_cnt(6'd1);
      pulse_start();
      chk("wrap_entry", 8'(state), 8'd1);
      for (int k = 0; k < 64; k++) period("wrap");
      chk("wrap_cnt0", 8'(cnt), 8'd0);
      chk("wrap_state", 8'(state), 8'd1);
      chk("wrap_done", 8'(done), 8'd0);
      cyc();
      chk("wrap_cnt1", 8'(cnt), 8'd1);

      // halt at TERM: four pulses take 1 to 5, then DONE
      do_reset();
      load_cnt(6'd1);
      mode_wrap = 1'b0;
      pulse_start();
      for (int k = 0; k < 4; k++) period("halt");
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("halt_quiet5", 8'(cnt_en), 8'd0);
      end
      cyc();
      chk("halt_state", 8'(state), 8'd3);
      chk("halt_done", 8'(done), 8'd1);
      chk("halt_en", 8'(cnt_en), 8'd0);
      chk("halt_cnt", 8'(cnt), 8'd5);
      count_pulses(8);
      chk("halt_nopulse", 8'(pulses), 8'd0);
      pulse_start();
      chk("done_start_ign", 8'(state), 8'd3);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      chk("done_stop_idle", 8'(state), 8'd0);
      chk("done_stop_done", 8'(done), 8'd0);

      // start and stop together in IDLE: stop wins
      start = 1'b1; stop = 1'b1;
      cyc();
      start = 1'b0; stop = 1'b0;
      chk("ss_idle", 8'(state), 8'd0);
      cyc();
      chk("ss_en", 8'(cnt_en), 8'd0);

`ifdef COUNTER_CTRL_STEP_EN
      step = 1'b1;
      cyc();
      step = 1'b0;
      chk("step_idle_state", 8'(state), 8'd2);
      chk("step_idle_en", 8'(cnt_en), 8'd1);
      cyc();
      chk("step_idle_en_off", 8'(cnt_en), 8'd0);
      chk("step_idle_cnt", 8'(cnt), 8'd6);
      pulse_start();
      step = 1'b1;
      cyc();
      step = 1'b0;
      chk("step_run_state", 8'(state), 8'd1);
      chk("step_run_en", 8'(cnt_en), 8'd0);
      do_reset();
      load_cnt(6'd5);
      mode_wrap = 1'b0;
      pulse_start();
      count_pulses(4);
      chk("step_done_reach", 8'(state), 8'd3);
      step = 1'b1;
      cyc();
      step = 1'b0;
      chk("step_done_state", 8'(state), 8'd2);
      chk("step_done_en", 8'(cnt_en), 8'd1);
      cyc();
      chk("step_done_cnt", 8'(cnt), 8'd6);
      chk("step_done_en_off", 8'(cnt_en), 8'd0);
`else
      step = 1'b1;
      cyc();
      step = 1'b0;
      chk("nostep_state", 8'(state), 8'd0);
      chk("nostep_en", 8'(cnt_en), 8'd0);
      cyc();
      chk("nostep_en2", 8'(cnt_en), 8'd0);
      chk("nostep_cnt", 8'(cnt), 8'd5);
`endif

      // pause holds the prescaler; resume finishes the remaining two cycles
      do_reset();
      load_cnt(6'd0);
      mode_wrap = 1'b1;
      pulse_start();
      period("p34");
      cyc();
      cyc();
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      chk("pause_state", 8'(state), 8'd2);
      chk("pause_en", 8'(cnt_en), 8'd0);
      count_pulses(5);
      chk("pause_nopulse", 8'(pulses), 8'd0);
      pulse_start();
      chk("resume_state", 8'(state), 8'd1);
      chk("resume_en0", 8'(cnt_en), 8'd0);
      cyc();
      chk("resume_en1", 8'(cnt_en), 8'd0);
      cyc();
      chk("resume_pulse", 8'(cnt_en), 8'd1);
      cyc();
      chk("resume_cnt", 8'(cnt), 8'd2);
      cyc();
      cyc();
      // stop on the terminal edge suppresses that pulse
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      chk("supp_en", 8'(cnt_en), 8'd0);
      chk("supp_state", 8'(state), 8'd2);

      // asynchronous reset mid-RUN with the prescaler at its terminal value
      pulse_start();
      chk("arst_run", 8'(state), 8'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_state", 8'(state), 8'd0);
      chk("arst_en", 8'(cnt_en), 8'd0);
      chk("arst_done", 8'(done), 8'd0);
      cyc();
      chk("arst_hold_en", 8'(cnt_en), 8'd0);
      rst = 1'b1;
      count_pulses(8);
      chk("arst_nopulse", 8'(pulses), 8'd0);
      chk("arst_idle", 8'(state), 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
